// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   seq_state_e   : FSM state encoding (fixed 2-bit values, visible on debug taps)
//   seq_cnt_width : width of the shared cycle counter so it can hold the
//                   largest terminal count of any state without wrapping
package pll_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RESET = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_e;

  // clog2(max(a, b, c) + 1): enough bits to count 0..max.
  function automatic int seq_cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_lock_sync.sv
// Two-flop synchronizer for a single level signal crossing into the clk domain.
// Kept generic so the same block can sit on the clk2 side of the design.
//   clk  in  destination clock
//   rst  in  asynchronous active-high reset, clears both flops to 0
//   d    in  asynchronous level input
//   q    out synchronized level, two clk edges of latency
module pll_reset_sequencer_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: drives PLL RST, watches PLL LOCKED and only releases
// the downstream system reset once lock has been continuously stable.
// A lock loss while running re-asserts sys_rst and restarts the PLL.
//
// Ports
//   clk            in   free-running reference clock (pre-PLL)
//   rst            in   asynchronous active-high reset
//   pll_locked     in   PLL LOCKED, asynchronous to clk
//   pll_rst        out  PLL RST, active-high
//   sys_rst        out  downstream reset, active-high
//   ready          out  high only while in RUN
//   timeout        out  one-cycle pulse when a lock wait expires
//   lock_loss_cnt  out  saturating count of RUN -> lock-lost events
//
// States
//   state         | meaning
//   --------------+--------------------------------------------------------
//   ST_PLL_RESET  | pll_rst held high for PLL_RST_CYCLES cycles
//   ST_WAIT_LOCK  | PLL released, waiting up to LOCK_TIMEOUT cycles for lock
//   ST_STABLE     | lock seen, needs LOCK_STABLE_CYCLES unbroken lock samples
//   ST_RUN        | system out of reset; any lock drop restarts the PLL
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT       = 65535,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic                  sys_rst,
  output logic                  ready,
  output logic                  timeout,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int CNT_W = seq_cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT);

  // Terminal counts: the counter starts at 0 on state entry, so N cycles end at N-1.
  localparam logic [CNT_W-1:0] RST_TC     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_TC  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX = {LOSS_CNT_W{1'b1}};

  logic lock_s;

  seq_state_e            state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic                  pll_rst_q, pll_rst_d;
  logic                  sys_rst_q, sys_rst_d;
  logic                  ready_q,   ready_d;
  logic                  timeout_q, timeout_d;
  logic [LOSS_CNT_W-1:0] loss_q,    loss_d;

  pll_reset_sequencer_lock_sync u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    loss_d    = loss_q;

    case (state_q)
      ST_PLL_RESET: begin
        if (cnt_q == RST_TC) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_LOCK: begin
        // Lock is checked before the timeout so a lock arriving on the
        // expiry cycle is not thrown away by a needless PLL reset.
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_TC) begin
          state_d   = ST_PLL_RESET;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STABLE: begin
        // Any dropout discards the accumulated stable time, including on
        // the final cycle.
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_TC) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_PLL_RESET;
          cnt_d   = '0;
          if (loss_q != LOSS_MAX) begin
            loss_d = loss_q + LOSS_CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_PLL_RESET;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register, without a combinational path to the pins.
    pll_rst_d = (state_d == ST_PLL_RESET);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_PLL_RESET;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      timeout_q <= 1'b0;
      loss_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      timeout_q <= timeout_d;
      loss_q    <= loss_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst       = sys_rst_q;
  assign ready         = ready_q;
  assign timeout       = timeout_q;
  assign lock_loss_cnt = loss_q;

endmodule
